// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - committed-store FIFO with write-out port and load forwarding lookup
//
// Purpose:
//   Circular buffer of committed stores. Up to COMMIT_WIDTH stores enter per
//   cycle (compacted at the tail), one store per cycle drains through the
//   memory write port, and LOAD_PORTS combinational lookups search the
//   buffered stores for the youngest word-address match.
//
// Optional feature (macro STORE_BUFFER_FWD_EN):
//   defined   - full forwarding: exact WORD/WORD matches return data (fwd_hit),
//               any other selected match raises fwd_conflict.
//   undefined - no data forwarding: fwd_hit=0, fwd_data=0 and fwd_conflict
//               flags any word-address match.
//
// Mode encoding (ldst_mode, 2 bits): 0 = BYTE, 1 = HALF, 2 = WORD.
//
// Ports:
//   clk, reset                   clock, asynchronous active-high reset
//   in_valid/in_addr/in_data/in_mode   per-lane committed store
//   in_ready                     room for COMMIT_WIDTH stores this cycle
//   mem_we/mem_wa/mem_wd/mem_wm  head entry presented to memory
//   mem_ack                      memory accepted the head entry
//   ld_addr/ld_mode              per-port load lookup
//   fwd_hit/fwd_data/fwd_conflict per-port lookup result
//   count, empty                 occupancy

module store_buffer #(
    parameter int DEPTH        = 8,
    parameter int COMMIT_WIDTH = 2,
    parameter int LOAD_PORTS   = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [COMMIT_WIDTH-1:0]             in_valid,
    input  logic [COMMIT_WIDTH-1:0][31:0]       in_addr,
    input  logic [COMMIT_WIDTH-1:0][31:0]       in_data,
    input  logic [COMMIT_WIDTH-1:0][1:0]        in_mode,
    output logic                                in_ready,
    output logic                                mem_we,
    output logic [31:0]                         mem_wa,
    output logic [31:0]                         mem_wd,
    output logic [1:0]                          mem_wm,
    input  logic                                mem_ack,
    input  logic [LOAD_PORTS-1:0][31:0]         ld_addr,
    input  logic [LOAD_PORTS-1:0][1:0]          ld_mode,
    output logic [LOAD_PORTS-1:0]               fwd_hit,
    output logic [LOAD_PORTS-1:0][31:0]         fwd_data,
    output logic [LOAD_PORTS-1:0]               fwd_conflict,
    output logic [$clog2(DEPTH):0]              count,
    output logic                                empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [1:0] MODE_WORD = 2'd2;

    // Entry storage is not reset: only entries inside [head, head+count) are ever observed.
    logic [31:0] r_addr [DEPTH];
    logic [31:0] r_data [DEPTH];
    logic [1:0]  r_mode [DEPTH];

    logic [AW-1:0] r_head;
    logic [AW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [CW-1:0]                w_free;
    logic [CW-1:0]                w_n_acc;
    logic [COMMIT_WIDTH-1:0]      w_take;
    logic [AW-1:0]                w_slot [COMMIT_WIDTH];
    logic                         w_pop;

    assign count    = r_count;
    assign empty    = (r_count == '0);
    assign w_free   = CW'(DEPTH) - r_count;
    assign in_ready = (w_free >= CW'(COMMIT_WIDTH));

    // Head entry is shown only while valid so reset and empty both present zeros.
    assign mem_we = !empty;
    assign mem_wa = empty ? 32'd0 : r_addr[r_head];
    assign mem_wd = empty ? 32'd0 : r_data[r_head];
    assign mem_wm = empty ? 2'd0  : r_mode[r_head];
    assign w_pop  = mem_we && mem_ack;

    // Valid lanes are packed into consecutive slots starting at the tail;
    // an invalid lane does not advance the slot offset.
    always_comb begin : p_compact
        logic [CW-1:0] v_off;
        v_off = '0;
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
            w_slot[l] = r_tail + v_off[AW-1:0];
            w_take[l] = in_ready && in_valid[l];
            if (w_take[l]) begin
                v_off = v_off + CW'(1);
            end
        end
        w_n_acc = v_off;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + w_n_acc[AW-1:0];
            if (w_pop) begin
                r_head <= r_head + AW'(1);
            end
            r_count <= r_count + w_n_acc - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        for (int l = 0; l < COMMIT_WIDTH; l++) begin
            if (w_take[l]) begin
                r_addr[w_slot[l]] <= in_addr[l];
                r_data[w_slot[l]] <= in_data[l];
                r_mode[w_slot[l]] <= in_mode[l];
            end
        end
    end

    // Lookup walks entries oldest to youngest so the last match wins (youngest).
    // Only entries present at cycle start are searched; the head stays visible
    // during the cycle it pops.
`ifdef STORE_BUFFER_FWD_EN
    always_comb begin
        for (int p = 0; p < LOAD_PORTS; p++) begin
            logic          v_found;
            logic [AW-1:0] v_sel;
            logic [AW-1:0] v_idx;
            logic          v_hit;
            v_found = 1'b0;
            v_sel   = '0;
            for (int i = 0; i < DEPTH; i++) begin
                v_idx = r_head + AW'(i);
                if ((CW'(i) < r_count) && (r_addr[v_idx][31:2] == ld_addr[p][31:2])) begin
                    v_found = 1'b1;
                    v_sel   = v_idx;
                end
            end
            v_hit = v_found && (r_mode[v_sel] == MODE_WORD) && (ld_mode[p] == MODE_WORD)
                    && (r_addr[v_sel][1:0] == ld_addr[p][1:0]);
            fwd_hit[p]      = v_hit;
            fwd_data[p]     = v_hit ? r_data[v_sel] : 32'd0;
            fwd_conflict[p] = v_found && !v_hit;
        end
    end
`else
    logic w_unused_ld;
    assign w_unused_ld = ^{ld_mode, ld_addr};

    always_comb begin
        for (int p = 0; p < LOAD_PORTS; p++) begin
            logic          v_found;
            logic [AW-1:0] v_idx;
            v_found = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                v_idx = r_head + AW'(i);
                if ((CW'(i) < r_count) && (r_addr[v_idx][31:2] == ld_addr[p][31:2])) begin
                    v_found = 1'b1;
                end
            end
            fwd_hit[p]      = 1'b0;
            fwd_data[p]     = 32'd0;
            fwd_conflict[p] = v_found;
        end
    end
`endif

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - scoreboard bench for store_buffer with queue reference model

module tb_store_buffer;

    localparam int DEPTH = 8;
    localparam int CWD   = 2;
    localparam int LP    = 2;
    localparam logic [1:0] M_BYTE = 2'd0;
    localparam logic [1:0] M_HALF = 2'd1;
    localparam logic [1:0] M_WORD = 2'd2;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  mode;
    } st_t;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [CWD-1:0]         in_valid = '0;
    logic [CWD-1:0][31:0]   in_addr = '0;
    logic [CWD-1:0][31:0]   in_data = '0;
    logic [CWD-1:0][1:0]    in_mode = '0;
    logic                   in_ready;
    logic                   mem_we;
    logic [31:0]            mem_wa;
    logic [31:0]            mem_wd;
    logic [1:0]             mem_wm;
    logic                   mem_ack = 1'b0;
    logic [LP-1:0][31:0]    ld_addr = '0;
    logic [LP-1:0][1:0]     ld_mode = '0;
    logic [LP-1:0]          fwd_hit;
    logic [LP-1:0][31:0]    fwd_data;
    logic [LP-1:0]          fwd_conflict;
    logic [3:0]             count;
    logic                   empty;

    store_buffer #(.DEPTH(DEPTH), .COMMIT_WIDTH(CWD), .LOAD_PORTS(LP)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_addr(in_addr), .in_data(in_data), .in_mode(in_mode),
        .in_ready(in_ready),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd), .mem_wm(mem_wm), .mem_ack(mem_ack),
        .ld_addr(ld_addr), .ld_mode(ld_mode),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_conflict(fwd_conflict),
        .count(count), .empty(empty)
    );

    always #5 clk = ~clk;

    int  total = 0;
    int  bad   = 0;
    st_t model[$];
    st_t exp_q[$];

    logic [31:0] pool [6] = '{32'h200, 32'h204, 32'h202, 32'h201, 32'h300, 32'h10};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Youngest buffered store whose word address matches decides the result.
    function automatic void ref_fwd(input logic [31:0] la, input logic [1:0] lm,
                                    output logic h, output logic [31:0] d, output logic c);
        logic found;
        st_t  e;
        found = 1'b0;
        h = 1'b0; d = 32'd0; c = 1'b0;
        for (int i = model.size() - 1; i >= 0; i--) begin
            if (!found && model[i].addr[31:2] == la[31:2]) begin
                found = 1'b1;
                e = model[i];
            end
        end
`ifdef STORE_BUFFER_FWD_EN
        if (found) begin
            h = (e.mode == M_WORD) && (lm == M_WORD) && (e.addr == la);
            d = h ? e.data : 32'd0;
            c = !h;
        end
`else
        c = found;
`endif
    endfunction

    // Compare state-derived outputs with the model, then advance the model by one edge.
    task automatic step();
        logic        h, c, ready, pop;
        logic [31:0] d;
        int          n;
        st_t         e;
        n = model.size();
        check("count", count, n);
        check("empty", empty, n == 0);
        check("in_ready", in_ready, (DEPTH - n) >= CWD);
        check("mem_we", mem_we, n != 0);
        for (int p = 0; p < LP; p++) begin
            ref_fwd(ld_addr[p], ld_mode[p], h, d, c);
            check($sformatf("fwd_hit%0d", p), fwd_hit[p], h);
            check($sformatf("fwd_data%0d", p), fwd_data[p], d);
            check($sformatf("fwd_conflict%0d", p), fwd_conflict[p], c);
        end
        ready = (DEPTH - n) >= CWD;
        pop   = (n != 0) && mem_ack;
        if (pop) void'(model.pop_front());
        if (ready) begin
            for (int l = 0; l < CWD; l++) begin
                if (in_valid[l]) begin
                    e.addr = in_addr[l]; e.data = in_data[l]; e.mode = in_mode[l];
                    model.push_back(e);
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    task automatic tick();
        #1;
        step();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        in_valid = '0;
        mem_ack  = 1'b0;
    endtask

    task automatic set_lane(input int l, input logic [31:0] a, input logic [31:0] d, input logic [1:0] m);
        in_valid[l] = 1'b1; in_addr[l] = a; in_data[l] = d; in_mode[l] = m;
    endtask

    task automatic drain();
        in_valid = '0;
        mem_ack  = 1'b1;
        for (int k = 0; k < 40 && model.size() != 0; k++) tick();
        check("drain_done", model.size(), 0);
        mem_ack = 1'b0;
        tick();
    endtask

    // Scoreboard monitor: every accepted write-out must match the oldest expected store.
    initial begin
        st_t e;
        forever begin
            @(negedge clk);
            #3;
            if (!reset && mem_we && mem_ack) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_wa", mem_wa, e.addr);
                    check("sb_wd", mem_wd, e.data);
                    check("sb_wm", {30'd0, mem_wm}, {30'd0, e.mode});
                end
            end
        end
    end

    initial begin
        #3;
        check("rst_mem_we", mem_we, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_in_ready", in_ready, 1);
        check("rst_mem_wa", mem_wa, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_fwd_hit", fwd_hit, 0);
        check("rst_fwd_conflict", fwd_conflict, 0);
        @(negedge clk);
        reset = 1'b0;

        // Fill with 4 pairs, then a 5th pair must be ignored
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            set_lane(0, 32'h100, 32'h1000 + k, M_WORD);
            set_lane(1, 32'h104, 32'h2000 + k, M_WORD);
            tick();
        end
        idle_inputs();
        #1;
        check("fill_count", count, 8);
        check("fill_ready", in_ready, 0);
        step();
        @(negedge clk);
        drain();

        // Ordered drain of two stores, latency of one cycle
        idle_inputs();
        set_lane(0, 32'h10, 32'hA, M_WORD);
        set_lane(1, 32'h14, 32'hB, M_WORD);
        #1;
        check("lat_mem_we_same", mem_we, 0);
        step();
        @(negedge clk);
        idle_inputs();
        mem_ack = 1'b1;
        #1;
        check("order_wa0", mem_wa, 32'h10);
        step();
        @(negedge clk);
        #1;
        check("order_wa1", mem_wa, 32'h14);
        step();
        @(negedge clk);
        #1;
        check("order_empty", empty, 1);
        step();
        @(negedge clk);

        // Simultaneous enqueue and pop at count 6, wrapping the ring
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            set_lane(0, 32'h500 + 8 * k, 32'h50 + k, M_WORD);
            set_lane(1, 32'h504 + 8 * k, 32'h60 + k, M_HALF);
            tick();
        end
        set_lane(0, 32'h600, 32'h77, M_BYTE);
        set_lane(1, 32'h604, 32'h78, M_WORD);
        mem_ack = 1'b1;
        #1;
        check("simul_count_before", count, 6);
        step();
        @(negedge clk);
        idle_inputs();
        #1;
        check("simul_count_after", count, 7);
        step();
        @(negedge clk);
        drain();

        // Forwarding: two stores to 0x200, youngest wins
        idle_inputs();
        set_lane(0, 32'h200, 32'd1, M_WORD);
        set_lane(1, 32'h200, 32'd2, M_WORD);
        tick();
        idle_inputs();
        ld_addr[0] = 32'h200; ld_mode[0] = M_WORD;
`ifdef STORE_BUFFER_FWD_EN
        ld_addr[1] = 32'h202; ld_mode[1] = M_HALF;
        #1;
        check("fwd_hit_word", fwd_hit[0], 1);
        check("fwd_data_word", fwd_data[0], 2);
        check("fwd_conflict_half", fwd_conflict[1], 1);
        check("fwd_half_nohit", fwd_hit[1], 0);
`else
        ld_addr[1] = 32'h400; ld_mode[1] = M_WORD;
        #1;
        check("nofwd_hit", fwd_hit[0], 0);
        check("nofwd_conflict", fwd_conflict[0], 1);
        check("nofwd_miss_hit", fwd_hit[1], 0);
        check("nofwd_miss_conflict", fwd_conflict[1], 0);
`endif
        step();
        @(negedge clk);
        drain();

        // Asynchronous reset while draining is stalled at count 3
        idle_inputs();
        set_lane(0, 32'h700, 32'h7, M_WORD);
        set_lane(1, 32'h704, 32'h8, M_WORD);
        tick();
        idle_inputs();
        set_lane(0, 32'h708, 32'h9, M_WORD);
        tick();
        idle_inputs();
        #1;
        check("prerst_count", count, 3);
        check("prerst_mem_we", mem_we, 1);
        #1;
        reset = 1'b1;
        model.delete();
        exp_q.delete();
        #1;
        check("arst_mem_we", mem_we, 0);
        check("arst_count", count, 0);
        check("arst_empty", empty, 1);
        @(negedge clk);
        reset = 1'b0;
        set_lane(0, 32'h300, 32'h33, M_WORD);
        tick();
        idle_inputs();
        #1;
        check("post_rst_mem_we", mem_we, 1);
        check("post_rst_wa", mem_wa, 32'h300);
        step();
        @(negedge clk);
        drain();

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            in_valid = 2'($urandom_range(0, 3));
            for (int l = 0; l < CWD; l++) begin
                in_addr[l] = pool[$urandom_range(0, 5)];
                in_data[l] = $urandom;
                in_mode[l] = 2'($urandom_range(0, 2));
            end
            for (int p = 0; p < LP; p++) begin
                ld_addr[p] = pool[$urandom_range(0, 5)];
                ld_mode[p] = 2'($urandom_range(0, 2));
            end
            mem_ack = ($urandom_range(0, 99) < 45);
            tick();
        end
        drain();
        check("sb_empty_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
